// File: rtl/activity_display_pkg.sv
// Shared encodings and the display payload for the activity display path.
package activity_display_pkg;

    localparam int unsigned BCD_W   = 16;
    localparam int unsigned DP_W    = 4;
    localparam int unsigned BCD_MAX = 9999;
    localparam logic [DP_W-1:0] DP_DIST = 4'b0100;

    typedef enum logic [1:0] {
        MODE_STEPS  = 2'd0,
        MODE_DIST   = 2'd1,
        MODE_OVER32 = 2'd2,
        MODE_HIGHA  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    typedef struct packed {
        mode_e             mode;
        logic [BCD_W-1:0]  bcd;
        logic [DP_W-1:0]   dp_en;
        logic              sat;
    } disp_t;

    // Distance is shown in hundredths, so its point sits after the second digit.
    function automatic logic [DP_W-1:0] dp_for_mode(input mode_e m);
        return (m == MODE_DIST) ? DP_DIST : DP_W'(0);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, four BCD digits out.
module bin2bcd_seq
    import activity_display_pkg::*;
#(
    parameter int unsigned W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Add-3 correction on every digit that would overflow when doubled.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = CNT_W'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = BCD_W'({adj, bin_q[W-1]});
            bin_d = {bin_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/activity_display_scheduler.sv
// Rotates through four activity metrics and refreshes the BCD display once per second.
module activity_display_scheduler
    import activity_display_pkg::*;
#(
    parameter int unsigned VAL_W     = 14,
    parameter int unsigned DWELL_SEC = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sec_tick,
    input  logic             run_en,
    input  logic [VAL_W-1:0] steps,
    input  logic [VAL_W-1:0] distance,
    input  logic [VAL_W-1:0] over32_secs,
    input  logic [VAL_W-1:0] higha_time,
    output logic [1:0]       mode,
    output logic [15:0]      bcd,
    output logic [3:0]       dp_en,
    output logic             sat,
    output logic             disp_valid,
    output logic             busy
);

    localparam int unsigned DWELL_W = 4;

    state_e             state_q, state_d;
    mode_e              next_mode_q, next_mode_d;
    mode_e              lat_mode_q, lat_mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               pending_q, pending_d;
    logic               lat_sat_q, lat_sat_d;
    disp_t              disp_q, disp_d;
    logic               disp_valid_q, disp_valid_d;
    logic               busy_q, busy_d;

    logic               conv_start, conv_busy, conv_done;
    logic [VAL_W-1:0]   metric, conv_in;
    logic               metric_sat;
    logic [BCD_W-1:0]   conv_bcd;

    always_comb begin
        metric = steps;
        unique case (next_mode_q)
            MODE_STEPS:  metric = steps;
            MODE_DIST:   metric = distance;
            MODE_OVER32: metric = over32_secs;
            MODE_HIGHA:  metric = higha_time;
        endcase
    end

    assign metric_sat = (metric > VAL_W'(BCD_MAX));
    assign conv_in    = metric_sat ? VAL_W'(BCD_MAX) : metric;

    always_comb begin
        state_d      = state_q;
        next_mode_d  = next_mode_q;
        lat_mode_d   = lat_mode_q;
        dwell_d      = dwell_q;
        pending_d    = pending_q;
        lat_sat_d    = lat_sat_q;
        disp_d       = disp_q;
        disp_valid_d = 1'b0;
        conv_start   = 1'b0;

        // Rotation counts every tick, independent of conversion progress.
        if (sec_tick && run_en) begin
            if (dwell_q == DWELL_W'(DWELL_SEC - 1)) begin
                dwell_d     = '0;
                next_mode_d = mode_e'(next_mode_q + 2'd1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sec_tick || pending_q) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                lat_mode_d = next_mode_q;
                lat_sat_d  = metric_sat;
                pending_d  = 1'b0;
                conv_start = 1'b1;
                state_d    = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (conv_done) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                disp_d.mode  = lat_mode_q;
                disp_d.bcd   = conv_bcd;
                disp_d.dp_en = dp_for_mode(lat_mode_q);
                disp_d.sat   = lat_sat_q;
                disp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase

        // A tick arriving mid-refresh must win over the clear in LATCH.
        if (sec_tick && (state_q != ST_IDLE)) pending_d = 1'b1;

        busy_d = (state_d != ST_IDLE) || conv_busy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            next_mode_q  <= MODE_STEPS;
            lat_mode_q   <= MODE_STEPS;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            lat_sat_q    <= 1'b0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_mode_q  <= next_mode_d;
            lat_mode_q   <= lat_mode_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            lat_sat_q    <= lat_sat_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
        end
    end

    bin2bcd_seq #(.W(VAL_W)) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (conv_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    assign mode       = disp_q.mode;
    assign bcd        = disp_q.bcd;
    assign dp_en      = disp_q.dp_en;
    assign sat        = disp_q.sat;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_activity_display_scheduler.sv
// Bench for activity_display_scheduler: latency/rotation model plus directed literal checks.
module tb_activity_display_scheduler;

    localparam int unsigned VAL_W     = 14;
    localparam int unsigned DWELL_SEC = 2;
    localparam int          LAT       = 17;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             sec_tick = 1'b0;
    logic             run_en = 1'b0;
    logic [VAL_W-1:0] steps = '0;
    logic [VAL_W-1:0] distance = '0;
    logic [VAL_W-1:0] over32_secs = '0;
    logic [VAL_W-1:0] higha_time = '0;
    logic [1:0]       mode;
    logic [15:0]      bcd;
    logic [3:0]       dp_en;
    logic             sat, disp_valid, busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    activity_display_scheduler #(.VAL_W(VAL_W), .DWELL_SEC(DWELL_SEC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sec_tick    (sec_tick),
        .run_en      (run_en),
        .steps       (steps),
        .distance    (distance),
        .over32_secs (over32_secs),
        .higha_time  (higha_time),
        .mode        (mode),
        .bcd         (bcd),
        .dp_en       (dp_en),
        .sat         (sat),
        .disp_valid  (disp_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          launch = -1;
    int          m_dwell = 0;
    int          m_next = 0;
    int          cap_mode = 0;
    int          cap_val = 0;
    bit          m_pend = 1'b0;
    bit          cap_sat = 1'b0;
    logic [1:0]  e_mode = '0;
    logic [15:0] e_bcd = '0;
    logic [3:0]  e_dp = '0;
    logic        e_sat = 1'b0, e_valid = 1'b0, e_busy = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int metric_of(input int m);
        case (m)
            0:       return int'(steps);
            1:       return int'(distance);
            2:       return int'(over32_secs);
            default: return int'(higha_time);
        endcase
    endfunction

    // A refresh launched at edge L samples the metric at L+1 and shows it at L+LAT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; launch = -1; m_dwell = 0; m_next = 0; m_pend = 1'b0;
            e_mode = '0; e_bcd = '0; e_dp = '0; e_sat = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
        end else begin : model_step
            bit busy_now;
            int v;
            cyc++;
            busy_now = (launch >= 0);
            if (busy_now && cyc == launch + 1) begin
                v        = metric_of(m_next);
                cap_mode = m_next;
                cap_sat  = (v > 9999);
                cap_val  = cap_sat ? 9999 : v;
                m_pend   = 1'b0;
            end
            e_valid = 1'b0;
            if (busy_now && cyc == launch + LAT) begin
                e_bcd   = to_bcd(cap_val);
                e_mode  = 2'(cap_mode);
                e_dp    = (cap_mode == 1) ? 4'b0100 : 4'b0000;
                e_sat   = cap_sat;
                e_valid = 1'b1;
                launch  = -1;
            end
            if (busy_now && sec_tick) m_pend = 1'b1;
            if (!busy_now && (sec_tick || m_pend)) launch = cyc;
            if (sec_tick && run_en) begin
                if (m_dwell == int'(DWELL_SEC) - 1) begin
                    m_dwell = 0;
                    m_next  = (m_next + 1) % 4;
                end else begin
                    m_dwell = m_dwell + 1;
                end
            end
            e_busy = (launch >= 0);
        end
    end

    // Every cycle the outputs must match the model.
    always @(negedge clk) begin
        checks++;
        if ({mode, bcd, dp_en, sat, disp_valid, busy} !== {e_mode, e_bcd, e_dp, e_sat, e_valid, e_busy}) begin
            errors++;
            $display("FAIL cycle_model t=%0t dut mode=%0d bcd=%h dp=%b sat=%b valid=%b busy=%b required mode=%0d bcd=%h dp=%b sat=%b valid=%b busy=%b",
                     $time, mode, bcd, dp_en, sat, disp_valid, busy, e_mode, e_bcd, e_dp, e_sat, e_valid, e_busy);
        end
        if (disp_valid === 1'b1) valid_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        step();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (disp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_valid_timeout actual=no_pulse required=pulse_within_%0d", maxc);
        end
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  exp_m [8];
        logic [15:0] vals  [4];
        int          v0;
        exp_m = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        vals  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

        // Reset with nonzero metrics
        steps = 14'd1234; distance = 14'd500; over32_secs = 14'd77; higha_time = 14'd88;
        #1 reset_n = 1'b0;
        step(); step(); step();
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (5) step();
        chk("no_valid_before_tick", 32'(valid_cnt), 32'd0);

        // Single refresh: exact latency
        tick();
        repeat (LAT - 1) step();
        chk("latency_early", 32'(disp_valid), 32'h0);
        step();
        chk("latency_valid", 32'(disp_valid), 32'h1);
        chk("first_bcd", 32'(bcd), 32'h1234);
        chk("first_mode", 32'(mode), 32'h0);
        chk("first_dp", 32'(dp_en), 32'h0);
        chk("first_sat", 32'(sat), 32'h0);
        step();
        chk("valid_one_cycle", 32'(disp_valid), 32'h0);

        // Rotation through all modes
        do_reset();
        steps = 14'd11; distance = 14'd22; over32_secs = 14'd33; higha_time = 14'd44;
        run_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            wait_valid(30);
            chk($sformatf("rot_mode_%0d", t), 32'(mode), 32'(exp_m[t]));
            chk($sformatf("rot_bcd_%0d", t), 32'(bcd), 32'(vals[exp_m[t]]));
            chk($sformatf("rot_dp_%0d", t), 32'(dp_en), (exp_m[t] == 2'd1) ? 32'h4 : 32'h0);
            repeat (20) step();
        end

        // Saturation boundary
        run_en = 1'b0;
        steps = 14'd12000;
        tick();
        wait_valid(30);
        chk("sat_bcd", 32'(bcd), 32'h9999);
        chk("sat_flag", 32'(sat), 32'h1);
        steps = 14'd9999;
        tick();
        wait_valid(30);
        chk("max_bcd", 32'(bcd), 32'h9999);
        chk("max_sat", 32'(sat), 32'h0);

        // Second tick mid-conversion becomes a pending refresh
        do_reset();
        run_en = 1'b1;
        steps = 14'd100; distance = 14'd100;
        v0 = valid_cnt;
        tick();
        step();
        steps = 14'd200; distance = 14'd200;
        repeat (2) step();
        tick();
        wait_valid(30);
        chk("pend_first_bcd", 32'(bcd), 32'h0100);
        chk("pend_first_mode", 32'(mode), 32'h0);
        wait_valid(30);
        chk("pend_second_bcd", 32'(bcd), 32'h0200);
        chk("pend_second_mode", 32'(mode), 32'h1);
        chk("pend_second_dp", 32'(dp_en), 32'h4);
        repeat (25) step();
        chk("pend_pulse_count", 32'(valid_cnt - v0), 32'd2);

        // Reset during conversion aborts without a pulse
        run_en = 1'b0;
        steps = 14'd555;
        tick();
        repeat (5) step();
        chk("abort_pre_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_mode", 32'(mode), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        step(); step();
        reset_n = 1'b1;
        v0 = valid_cnt;
        repeat (25) step();
        chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        steps = 14'd321;
        tick();
        wait_valid(30);
        chk("post_abort_bcd", 32'(bcd), 32'h0321);
        chk("post_abort_mode", 32'(mode), 32'h0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
